// File: rtl/dsp_wb_regs.sv
// dsp_wb_regs: Wishbone B3 slave register bank for the DSP engine (bus in/out, INPUT0-4 operand regs out, OUTPUT0-4 results in, start/done/error handshake, interrupt out)
module dsp_wb_regs #(
  parameter int dw = 32,
  parameter int aw = 32,
  parameter int DEBUG = 0
) (
  input  logic            wb_clk,
  input  logic            wb_rst,
  input  logic [aw-1:0]   wb_adr_i,
  input  logic [dw-1:0]   wb_dat_i,
  input  logic [dw/8-1:0] wb_sel_i,
  input  logic            wb_we_i,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  output logic [dw-1:0]   wb_dat_o,
  output logic            wb_ack_o,
  output logic            wb_err_o,
  output logic [dw-1:0]   dsp_input0_reg,
  output logic [dw-1:0]   dsp_input1_reg,
  output logic [dw-1:0]   dsp_input2_reg,
  output logic [dw-1:0]   dsp_input3_reg,
  output logic [dw-1:0]   dsp_input4_reg,
  input  logic [dw-1:0]   dsp_output0_reg,
  input  logic [dw-1:0]   dsp_output1_reg,
  input  logic [dw-1:0]   dsp_output2_reg,
  input  logic [dw-1:0]   dsp_output3_reg,
  input  logic [dw-1:0]   dsp_output4_reg,
  output logic            dsp_start,
  input  logic            dsp_done,
  input  logic            dsp_error,
  output logic            interrupt
);
  logic [dw-1:0] in_q [5];
  logic [dw-1:0] outs [5];
  logic [dw-1:0] rdata;
  logic [5:0] adr;
  logic req, mapped, wr, wr_ctl, wr_st, start_w;
  logic irq_en, busy, start_pend, sts_done, sts_err, sts_ovr;
  logic unused;
  assign unused = ^{wb_adr_i[aw-1:8], wb_adr_i[1:0], DEBUG != 0};
  assign adr = wb_adr_i[7:2];
  assign req = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
  assign mapped = adr <= 6'd11;
  assign wr = req & wb_we_i;
  assign wr_ctl = wr & (adr == 6'd10);
  assign wr_st = wr & (adr == 6'd11);
  assign start_w = wr_ctl & wb_dat_i[0];
  assign outs = '{dsp_output0_reg, dsp_output1_reg, dsp_output2_reg, dsp_output3_reg, dsp_output4_reg};
  assign dsp_input0_reg = in_q[0];
  assign dsp_input1_reg = in_q[1];
  assign dsp_input2_reg = in_q[2];
  assign dsp_input3_reg = in_q[3];
  assign dsp_input4_reg = in_q[4];
  always_comb begin
    rdata = adr <= 6'd4 ? in_q[adr[2:0]] :
            adr <= 6'd9 ? outs[3'(adr - 6'd5)] :
            adr == 6'd10 ? dw'({irq_en, 1'b0}) :
            adr == 6'd11 ? dw'({sts_ovr, sts_err, sts_done, busy}) : '0;
  end
  // START is captured on the ack edge and launched one edge later, so the
  // engine pulse and BUSY rise together in the cycle following ack.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
      in_q <= '{default: '0};
      irq_en <= 1'b0;
      start_pend <= 1'b0;
      dsp_start <= 1'b0;
      busy <= 1'b0;
      sts_done <= 1'b0;
      sts_err <= 1'b0;
      sts_ovr <= 1'b0;
      interrupt <= 1'b0;
    end else begin
      wb_ack_o <= req & mapped;
      wb_err_o <= req & ~mapped;
      if (req & ~wb_we_i) wb_dat_o <= rdata;
      for (int i = 0; i < 5; i++)
        if (wr && adr == 6'(i))
          for (int b = 0; b < dw/8; b++)
            if (wb_sel_i[b]) in_q[i][8*b +: 8] <= wb_dat_i[8*b +: 8];
      if (wr_ctl) irq_en <= wb_dat_i[1];
      start_pend <= start_w & ~busy & ~start_pend;
      dsp_start <= start_pend;
      busy <= start_pend | (busy & ~dsp_done & ~dsp_error);
      sts_done <= dsp_done | (sts_done & ~(wr_st & wb_dat_i[1]));
      sts_err <= dsp_error | (sts_err & ~(wr_st & wb_dat_i[2]));
      sts_ovr <= (start_w & (busy | start_pend)) | (sts_ovr & ~(wr_st & wb_dat_i[3]));
      interrupt <= irq_en & (sts_done | sts_err | sts_ovr);
    end
  end
endmodule

// File: tb/tb_dsp_wb_regs.sv
// tb_dsp_wb_regs: randomized self-checking bench for dsp_wb_regs against a register-map model
module tb_dsp_wb_regs;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  logic [31:0] adr, wdat, dat_o;
  logic [3:0] sel;
  logic we, cyc, stb, ack, err;
  logic [31:0] din [5];
  logic [31:0] dout [5];
  logic start, done, error, irq;
  int errors = 0, checks = 0, starts = 0;
  logic [31:0] m_in [5];
  logic m_irq_en, m_busy, m_done, m_err, m_ovr;

  dsp_wb_regs dut (
    .wb_clk(clk), .wb_rst(rst), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
    .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_dat_o(dat_o), .wb_ack_o(ack), .wb_err_o(err),
    .dsp_input0_reg(din[0]), .dsp_input1_reg(din[1]), .dsp_input2_reg(din[2]),
    .dsp_input3_reg(din[3]), .dsp_input4_reg(din[4]),
    .dsp_output0_reg(dout[0]), .dsp_output1_reg(dout[1]), .dsp_output2_reg(dout[2]),
    .dsp_output3_reg(dout[3]), .dsp_output4_reg(dout[4]),
    .dsp_start(start), .dsp_done(done), .dsp_error(error), .interrupt(irq)
  );

  always @(posedge clk) if (start) starts <= starts + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    for (int b = 0; b < 4; b++) if (s[b]) o[8*b +: 8] = n[8*b +: 8];
    return o;
  endfunction

  function automatic logic [31:0] exp_read(input int w);
    if (w < 5) return m_in[w];
    if (w < 10) return dout[w-5];
    if (w == 10) return {30'd0, m_irq_en, 1'b0};
    if (w == 11) return {28'd0, m_ovr, m_err, m_done, m_busy};
    return 32'd0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 5; i++) m_in[i] = 32'd0;
    {m_irq_en, m_busy, m_done, m_err, m_ovr} = 5'd0;
  endtask

  task automatic bus(input logic [7:0] a, input logic w, input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] rd, output logic ak, output logic er);
    @(posedge clk); #1;
    adr = {24'd0, a}; we = w; wdat = d; sel = s; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    ak = ack; er = err; rd = dat_o;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; adr = '0; wdat = '0; sel = '0; we = 0; cyc = 0; stb = 0; done = 0; error = 0;
    for (int i = 0; i < 5; i++) dout[i] = $urandom;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    checks++; if ({ack, err, start, irq} !== 4'd0) begin errors++; $display("FAIL reset_ctl: got %b want 0000", {ack, err, start, irq}); end
    checks++; if (dat_o !== 32'd0) begin errors++; $display("FAIL reset_dat: got %h want 0", dat_o); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (din[i] !== 32'd0) begin errors++; $display("FAIL reset_in%0d: got %h want 0", i, din[i]); end
    end
  endtask

  task automatic test_read_all();
    logic [31:0] rd; logic ak, er;
    for (int w = 0; w < 12; w++) begin
      bus(8'(w*4), 1'b0, 32'd0, 4'hF, rd, ak, er);
      checks++; if ({ak, er} !== 2'b10) begin errors++; $display("FAIL read_all_term%0d: ack/err %b want 10", w, {ak, er}); end
      checks++; if (rd !== exp_read(w)) begin errors++; $display("FAIL read_all_dat%0d: got %h want %h", w, rd, exp_read(w)); end
    end
    @(posedge clk); #1;
    checks++; if ({ack, err} !== 2'b00) begin errors++; $display("FAIL ack_one_cycle: got %b want 00", {ack, err}); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd; logic ak, er;
    bus(8'h08, 1'b1, 32'h11111111, 4'hF, rd, ak, er);
    m_in[2] = merge(m_in[2], 32'h11111111, 4'hF);
    bus(8'h08, 1'b1, 32'hDEADBEEF, 4'b0101, rd, ak, er);
    m_in[2] = merge(m_in[2], 32'hDEADBEEF, 4'b0101);
    checks++; if (din[2] !== 32'h11AD11EF) begin errors++; $display("FAIL byte_lanes_port: got %h want 11ad11ef", din[2]); end
    bus(8'h08, 1'b0, 32'd0, 4'hF, rd, ak, er);
    checks++; if (rd !== m_in[2]) begin errors++; $display("FAIL byte_lanes_read: got %h want %h", rd, m_in[2]); end
  endtask

  task automatic test_start_done();
    logic [31:0] rd; logic ak, er;
    bus(8'h28, 1'b1, 32'h3, 4'hF, rd, ak, er);
    m_irq_en = 1'b1;
    checks++; if ({ak, start} !== 2'b10) begin errors++; $display("FAIL start_ack_cycle: ack/start %b want 10", {ak, start}); end
    @(posedge clk); #1;
    m_busy = 1'b1;
    checks++; if (start !== 1'b1) begin errors++; $display("FAIL start_pulse: got %b want 1", start); end
    @(posedge clk); #1;
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL start_one_cycle: got %b want 0", start); end
    bus(8'h2C, 1'b0, 32'd0, 4'hF, rd, ak, er);
    checks++; if (rd !== exp_read(11)) begin errors++; $display("FAIL status_busy: got %h want %h", rd, exp_read(11)); end
    repeat (5) @(posedge clk);
    #1 done = 1'b1;
    @(posedge clk); #1 done = 1'b0;
    m_busy = 1'b0; m_done = 1'b1;
    @(posedge clk); #1;
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_on_done: got %b want 1", irq); end
    bus(8'h2C, 1'b0, 32'd0, 4'hF, rd, ak, er);
    checks++; if (rd !== exp_read(11)) begin errors++; $display("FAIL status_done: got %h want %h", rd, exp_read(11)); end
    bus(8'h2C, 1'b1, 32'h2, 4'hF, rd, ak, er);
    m_done = 1'b0;
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_hold_after_w1c: got %b want 1", irq); end
    @(posedge clk); #1;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b want 0", irq); end
  endtask

  task automatic test_overrun();
    logic [31:0] rd; logic ak, er; int s0;
    s0 = starts;
    bus(8'h28, 1'b1, 32'h3, 4'hF, rd, ak, er);
    repeat (3) @(posedge clk);
    #1 m_busy = 1'b1;
    checks++; if (starts !== s0 + 1) begin errors++; $display("FAIL first_start_count: got %0d want %0d", starts - s0, 1); end
    bus(8'h28, 1'b1, 32'h3, 4'hF, rd, ak, er);
    m_ovr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (starts !== s0 + 1) begin errors++; $display("FAIL overrun_no_pulse: got %0d want %0d", starts - s0, 1); end
    bus(8'h2C, 1'b0, 32'd0, 4'hF, rd, ak, er);
    checks++; if (rd !== 32'h9 || rd !== exp_read(11)) begin errors++; $display("FAIL status_overrun: got %h want %h", rd, exp_read(11)); end
    @(posedge clk); #1;
    adr = 32'h2C; we = 1'b1; wdat = 32'h2; sel = 4'hF; cyc = 1'b1; stb = 1'b1; done = 1'b1;
    @(posedge clk); #1;
    done = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    m_busy = 1'b0; m_done = 1'b1;
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL w1c_race_ack: got %b want 1", ack); end
    bus(8'h2C, 1'b0, 32'd0, 4'hF, rd, ak, er);
    checks++; if (rd !== exp_read(11)) begin errors++; $display("FAIL set_wins_w1c: got %h want %h", rd, exp_read(11)); end
    bus(8'h2C, 1'b1, 32'hE, 4'h0, rd, ak, er);
    {m_done, m_err, m_ovr} = 3'd0;
    bus(8'h2C, 1'b0, 32'd0, 4'hF, rd, ak, er);
    checks++; if (rd !== exp_read(11)) begin errors++; $display("FAIL status_cleared: got %h want %h", rd, exp_read(11)); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_after_clear: got %b want 0", irq); end
  endtask

  task automatic test_error_pulse();
    logic [31:0] rd; logic ak, er;
    @(posedge clk); #1 error = 1'b1;
    @(posedge clk); #1 error = 1'b0;
    m_err = 1'b1;
    bus(8'h2C, 1'b0, 32'd0, 4'hF, rd, ak, er);
    checks++; if (rd !== exp_read(11)) begin errors++; $display("FAIL error_idle: got %h want %h", rd, exp_read(11)); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_on_error: got %b want 1", irq); end
    bus(8'h2C, 1'b1, 32'h4, 4'hF, rd, ak, er);
    m_err = 1'b0;
  endtask

  task automatic test_unmapped();
    logic [31:0] rd; logic ak, er; logic [7:0] bad [2];
    bad = '{8'h30, 8'hFC};
    for (int k = 0; k < 2; k++) begin
      bus(8'h08, 1'b0, 32'd0, 4'hF, rd, ak, er);
      bus(bad[k], 1'b0, 32'd0, 4'hF, rd, ak, er);
      checks++; if ({ak, er} !== 2'b01) begin errors++; $display("FAIL unmapped_rd_term%0d: ack/err %b want 01", k, {ak, er}); end
      checks++; if (rd !== 32'd0) begin errors++; $display("FAIL unmapped_rd_dat%0d: got %h want 0", k, rd); end
      @(posedge clk); #1;
      checks++; if ({ack, err} !== 2'b00) begin errors++; $display("FAIL err_one_cycle%0d: got %b want 00", k, {ack, err}); end
      bus(bad[k], 1'b1, 32'hFFFFFFFF, 4'hF, rd, ak, er);
      checks++; if ({ak, er} !== 2'b01) begin errors++; $display("FAIL unmapped_wr_term%0d: ack/err %b want 01", k, {ak, er}); end
    end
    for (int w = 0; w < 12; w++) begin
      bus(8'(w*4), 1'b0, 32'd0, 4'hF, rd, ak, er);
      checks++; if (rd !== exp_read(w)) begin errors++; $display("FAIL unmapped_no_change%0d: got %h want %h", w, rd, exp_read(w)); end
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, d; logic ak, er; int i, w; logic [3:0] s;
    for (int n = 0; n < 40; n++) begin
      i = $urandom_range(0, 9); d = $urandom; s = 4'($urandom_range(0, 15));
      if (n % 8 == 0) for (int k = 0; k < 5; k++) dout[k] = $urandom;
      bus(8'(i*4), 1'b1, d, s, rd, ak, er);
      if (i < 5) m_in[i] = merge(m_in[i], d, s);
      checks++; if ({ak, er} !== 2'b10) begin errors++; $display("FAIL rand_wr_term%0d: ack/err %b want 10", n, {ak, er}); end
      if (i < 5) begin
        checks++; if (din[i] !== m_in[i]) begin errors++; $display("FAIL rand_port%0d: got %h want %h", i, din[i], m_in[i]); end
      end
      w = $urandom_range(0, 11);
      bus(8'(w*4), 1'b0, 32'd0, 4'hF, rd, ak, er);
      checks++; if (rd !== exp_read(w)) begin errors++; $display("FAIL rand_rd%0d_w%0d: got %h want %h", n, w, rd, exp_read(w)); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic ak, er;
    bus(8'h00, 1'b1, 32'hCAFEF00D, 4'hF, rd, ak, er);
    bus(8'h28, 1'b1, 32'h3, 4'hF, rd, ak, er);
    bus(8'h28, 1'b1, 32'h3, 4'hF, rd, ak, er);
    @(posedge clk); #1;
    checks++; if (irq !== 1'b1 || din[0] !== 32'hCAFEF00D) begin errors++; $display("FAIL pre_reset: irq %b in0 %h want 1 cafef00d", irq, din[0]); end
    adr = 32'h2C; we = 1'b0; cyc = 1'b1; stb = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; cyc = 1'b0; stb = 1'b0;
    model_reset();
    checks++; if ({ack, err, start, irq} !== 4'd0) begin errors++; $display("FAIL mid_reset_ctl: got %b want 0000", {ack, err, start, irq}); end
    checks++; if (din[0] !== 32'd0 || dat_o !== 32'd0) begin errors++; $display("FAIL mid_reset_regs: in0 %h dat %h want 0", din[0], dat_o); end
    @(posedge clk); #1;
    checks++; if ({ack, err} !== 2'b00) begin errors++; $display("FAIL mid_reset_noterm: got %b want 00", {ack, err}); end
    bus(8'h2C, 1'b0, 32'd0, 4'hF, rd, ak, er);
    checks++; if (rd !== exp_read(11)) begin errors++; $display("FAIL mid_reset_status: got %h want %h", rd, exp_read(11)); end
    bus(8'h28, 1'b0, 32'd0, 4'hF, rd, ak, er);
    checks++; if (rd !== exp_read(10)) begin errors++; $display("FAIL mid_reset_control: got %h want %h", rd, exp_read(10)); end
  endtask

  initial begin
    test_reset();
    test_read_all();
    test_byte_lanes();
    test_start_done();
    test_overrun();
    test_error_pulse();
    test_unmapped();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
